// File: rtl/pll_reset_sequencer.sv
// Purpose: drive the PLL reset, watch its lock indication and hold the system in reset until lock is stable.
// Latency: sys_rst falls SYNC_STAGES + LOCK_STABLE_CYCLES refclk cycles after pll_locked is first sampled high.
// Backpressure: none; free-running supervisor with no handshake, and every output is a registered level.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int SYNC_STAGES         = 2,
    parameter int CNT_W               = 17
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       err_clr,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       timeout_err,
    output logic [7:0] relock_count
);

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    // Terminal counts of the shared cycle counter for each timed state.
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   pll_rst_q, pll_rst_d;
    logic                   sys_rst_q, sys_rst_d;
    logic                   ready_q, ready_d;
    logic                   timeout_err_q, timeout_err_d;
    logic [7:0]             relock_count_q, relock_count_d;
    logic                   locked_s;

    // Only the last synchronizer stage is ever used for decisions.
    assign locked_s = sync_q[SYNC_STAGES-1];

    // Next-state, counter, sticky-status and Moore output decode from the next state.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        sync_d         = {sync_q[SYNC_STAGES-2:0], pll_locked};
        // A clear applies first so that a coincident event overrides it.
        timeout_err_d  = err_clr ? 1'b0 : timeout_err_q;
        relock_count_d = err_clr ? 8'd0 : relock_count_q;

        case (state_q)
            S_PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d       = S_PLL_RST;
                    cnt_d         = '0;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STABLE: begin
                // Any unlocked cycle restarts the lock wait, including its timeout window.
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if (!locked_s) begin
                    state_d = S_PLL_RST;
                    if (relock_count_d != 8'hFF) begin
                        relock_count_d = relock_count_d + 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_PLL_RST;
                cnt_d   = '0;
            end
        endcase

        pll_rst_d = (state_d == S_PLL_RST);
        sys_rst_d = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);
    end

    // All state, synchronizer and output registers; rst forces the power-on values at once.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q        <= S_PLL_RST;
            cnt_q          <= '0;
            sync_q         <= '0;
            pll_rst_q      <= 1'b1;
            sys_rst_q      <= 1'b1;
            ready_q        <= 1'b0;
            timeout_err_q  <= 1'b0;
            relock_count_q <= 8'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sync_q         <= sync_d;
            pll_rst_q      <= pll_rst_d;
            sys_rst_q      <= sys_rst_d;
            ready_q        <= ready_d;
            timeout_err_q  <= timeout_err_d;
            relock_count_q <= relock_count_d;
        end
    end

    assign pll_rst      = pll_rst_q;
    assign sys_rst      = sys_rst_q;
    assign ready        = ready_q;
    assign timeout_err  = timeout_err_q;
    assign relock_count = relock_count_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Purpose: directed self-checking bench for pll_reset_sequencer with small timing parameters.
// Latency: inputs driven and outputs sampled on the falling edge of refclk.
// Backpressure: not applicable.
module tb_pll_reset_sequencer;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       err_clr;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       timeout_err;
    logic [7:0] relock_count;

    int   tests_run;
    int   tests_failed;
    logic sys_rst_low_seen;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES     (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(32),
        .SYNC_STAGES        (2),
        .CNT_W              (17)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .err_clr     (err_clr),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .timeout_err (timeout_err),
        .relock_count(relock_count)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Hard stop in case something never terminates.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Assert rst for two cycles and release it on a falling edge; returns at the release point.
    task automatic apply_reset();
        @(negedge refclk);
        rst = 1'b1;
        repeat (2) @(negedge refclk);
        rst = 1'b0;
    endtask

    // Count consecutive falling-edge samples (starting now) where pll_rst equals val.
    task automatic measure_run(input logic val, output int len);
        len = 0;
        while (pll_rst === val && len < 200) begin
            if (sys_rst !== 1'b1) sys_rst_low_seen = 1'b1;
            len++;
            @(negedge refclk);
        end
    endtask

    // Wait until ready rises, at most limit falling edges; returns edges waited.
    task automatic wait_ready(input int limit, output int n);
        n = 0;
        while (ready !== 1'b1 && n < limit) begin
            @(negedge refclk);
            n++;
        end
    endtask

    task automatic test_reset();
        #1;
        tests_run++;
        if (pll_rst !== 1'b1) begin tests_failed++; $display("FAIL reset_pll_rst got %b want 1", pll_rst); end
        tests_run++;
        if (sys_rst !== 1'b1) begin tests_failed++; $display("FAIL reset_sys_rst got %b want 1", sys_rst); end
        tests_run++;
        if (ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready got %b want 0", ready); end
        tests_run++;
        if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout_err got %b want 0", timeout_err); end
        tests_run++;
        if (relock_count !== 8'd0) begin tests_failed++; $display("FAIL reset_relock_count got %0d want 0", relock_count); end
    endtask

    task automatic test_bringup();
        int len;
        int i;
        pll_locked = 1'b0;
        apply_reset();
        measure_run(1'b1, len);
        tests_run++;
        if (len != 4) begin tests_failed++; $display("FAIL bringup_pll_rst_width got %0d want 4", len); end
        repeat (6) @(negedge refclk);
        pll_locked = 1'b1;
        i = 0;
        while (sys_rst === 1'b1 && i < 100) begin
            @(negedge refclk);
            i++;
        end
        tests_run++;
        if (i - 1 != 10) begin tests_failed++; $display("FAIL bringup_latency got %0d want 10", i - 1); end
        tests_run++;
        if (ready !== 1'b1) begin tests_failed++; $display("FAIL bringup_ready got %b want 1", ready); end
        tests_run++;
        if (relock_count !== 8'd0) begin tests_failed++; $display("FAIL bringup_relock got %0d want 0", relock_count); end
        tests_run++;
        if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL bringup_timeout_err got %b want 0", timeout_err); end
    endtask

    task automatic test_timeout();
        int len;
        pll_locked = 1'b0;
        apply_reset();
        sys_rst_low_seen = 1'b0;
        measure_run(1'b1, len);
        tests_run++;
        if (len != 4) begin tests_failed++; $display("FAIL timeout_first_pulse got %0d want 4", len); end
        tests_run++;
        if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL timeout_err_early got %b want 0", timeout_err); end
        measure_run(1'b0, len);
        tests_run++;
        if (len != 32) begin tests_failed++; $display("FAIL timeout_low_gap got %0d want 32", len); end
        tests_run++;
        if (timeout_err !== 1'b1) begin tests_failed++; $display("FAIL timeout_err_set got %b want 1", timeout_err); end
        measure_run(1'b1, len);
        tests_run++;
        if (len != 4) begin tests_failed++; $display("FAIL timeout_second_pulse got %0d want 4", len); end
        tests_run++;
        if (sys_rst_low_seen !== 1'b0) begin tests_failed++; $display("FAIL timeout_sys_rst_low got %b want 0", sys_rst_low_seen); end
        // Plain clear with no event in that cycle.
        err_clr = 1'b1;
        @(negedge refclk);
        err_clr = 1'b0;
        tests_run++;
        if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL timeout_err_clear got %b want 0", timeout_err); end
        // Clear coincident with the next timeout: the timeout wins.
        repeat (30) @(negedge refclk);
        err_clr = 1'b1;
        @(negedge refclk);
        err_clr = 1'b0;
        tests_run++;
        if (timeout_err !== 1'b1 || pll_rst !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_clear_coincident got err=%b pll_rst=%b want 1 1", timeout_err, pll_rst);
        end
    endtask

    task automatic test_unstable();
        int  len;
        int  i;
        logic bad;
        pll_locked = 1'b0;
        apply_reset();
        measure_run(1'b1, len);
        bad = 1'b0;
        pll_locked = 1'b1;
        repeat (5) begin
            @(negedge refclk);
            if (pll_rst !== 1'b0 || sys_rst !== 1'b1) bad = 1'b1;
        end
        pll_locked = 1'b0;
        repeat (3) begin
            @(negedge refclk);
            if (pll_rst !== 1'b0 || sys_rst !== 1'b1) bad = 1'b1;
        end
        pll_locked = 1'b1;
        i = 0;
        while (sys_rst === 1'b1 && i < 100) begin
            @(negedge refclk);
            if (pll_rst !== 1'b0) bad = 1'b1;
            i++;
        end
        tests_run++;
        if (i - 1 != 10) begin tests_failed++; $display("FAIL unstable_latency got %0d want 10", i - 1); end
        tests_run++;
        if (bad !== 1'b0) begin tests_failed++; $display("FAIL unstable_outputs got glitch=%b want 0", bad); end
        tests_run++;
        if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL unstable_timeout_err got %b want 0", timeout_err); end
    endtask

    task automatic test_lock_loss();
        int len;
        int n;
        pll_locked = 1'b0;
        @(negedge refclk);
        tests_run++;
        if (ready !== 1'b1) begin tests_failed++; $display("FAIL loss_ready_edge1 got %b want 1", ready); end
        @(negedge refclk);
        tests_run++;
        if (sys_rst !== 1'b0 || ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL loss_still_run got sys_rst=%b ready=%b want 0 1", sys_rst, ready);
        end
        @(negedge refclk);
        tests_run++;
        if (sys_rst !== 1'b1 || pll_rst !== 1'b1 || ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL loss_reset_entry got sys_rst=%b pll_rst=%b ready=%b want 1 1 0", sys_rst, pll_rst, ready);
        end
        tests_run++;
        if (relock_count !== 8'd1) begin tests_failed++; $display("FAIL loss_relock got %0d want 1", relock_count); end
        pll_locked = 1'b1;
        measure_run(1'b1, len);
        tests_run++;
        if (len != 4) begin tests_failed++; $display("FAIL loss_pulse got %0d want 4", len); end
        wait_ready(60, n);
        tests_run++;
        if (n != 9) begin tests_failed++; $display("FAIL loss_rerun_time got %0d want 9", n); end
    endtask

    task automatic test_saturation();
        int n;
        int stuck;
        stuck = 0;
        for (int k = 0; k < 260; k++) begin
            pll_locked = 1'b0;
            repeat (3) @(negedge refclk);
            pll_locked = 1'b1;
            wait_ready(60, n);
            if (ready !== 1'b1) stuck++;
        end
        tests_run++;
        if (stuck != 0) begin tests_failed++; $display("FAIL sat_rerun got %0d stuck want 0", stuck); end
        tests_run++;
        if (relock_count !== 8'd255) begin tests_failed++; $display("FAIL sat_value got %0d want 255", relock_count); end
        err_clr = 1'b1;
        @(negedge refclk);
        err_clr = 1'b0;
        tests_run++;
        if (relock_count !== 8'd0) begin tests_failed++; $display("FAIL sat_clear got %0d want 0", relock_count); end
        // Clear in the same cycle as a lock loss.
        pll_locked = 1'b0;
        repeat (2) @(negedge refclk);
        err_clr = 1'b1;
        @(negedge refclk);
        err_clr = 1'b0;
        tests_run++;
        if (relock_count !== 8'd1 || pll_rst !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_clear_coincident got count=%0d pll_rst=%b want 1 1", relock_count, pll_rst);
        end
        pll_locked = 1'b1;
        wait_ready(60, n);
    endtask

    task automatic test_reset_mid_stable();
        int len;
        int n;
        pll_locked = 1'b0;
        repeat (3) @(negedge refclk);
        pll_locked = 1'b1;
        repeat (7) @(negedge refclk);
        tests_run++;
        if (pll_rst !== 1'b0 || sys_rst !== 1'b1 || relock_count !== 8'd2) begin
            tests_failed++;
            $display("FAIL midrst_in_stable got pll_rst=%b sys_rst=%b count=%0d want 0 1 2", pll_rst, sys_rst, relock_count);
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (pll_rst !== 1'b1 || sys_rst !== 1'b1 || ready !== 1'b0 || relock_count !== 8'd0 || timeout_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_async got pll_rst=%b sys_rst=%b ready=%b count=%0d err=%b want 1 1 0 0 0",
                     pll_rst, sys_rst, ready, relock_count, timeout_err);
        end
        @(negedge refclk);
        rst = 1'b0;
        measure_run(1'b1, len);
        tests_run++;
        if (len != 4) begin tests_failed++; $display("FAIL midrst_pulse got %0d want 4", len); end
        wait_ready(60, n);
        tests_run++;
        if (ready !== 1'b1 || relock_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL midrst_rerun got ready=%b count=%0d want 1 0", ready, relock_count);
        end
    endtask

    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        sys_rst_low_seen = 1'b0;
        rst              = 1'b1;
        pll_locked       = 1'b0;
        err_clr          = 1'b0;
        test_reset();
        test_bringup();
        test_timeout();
        test_unstable();
        test_lock_loss();
        test_saturation();
        test_reset_mid_stable();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Supervises the clock-generation PLL from its own side of the interface: drives the PLL reset input and reads back its lock indication.
- Holds the system in reset until lock has been stable for a programmable time.
- Re-initialises the PLL on lock loss or lock timeout.
- Runs on the free-running 50 MHz board reference; sits between the board reset and every block clocked from the PLL outputs.

Parameters:
- PLL_RST_CYCLES, 16: width of each PLL reset pulse, in refclk cycles (>=1).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before releasing system reset (>=1).
- LOCK_TIMEOUT_CYCLES, 65536: maximum wait for lock after the PLL reset pulse before retrying (>=2).
- SYNC_STAGES, 2: flip-flop stages synchronizing pll_locked into refclk (>=2).
- CNT_W, 17: width of the shared cycle counter; must hold max(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES).

Ports:
- refclk  input  1  free-running 50 MHz reference clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- pll_locked  input  1  PLL lock indication; asynchronous to refclk.
- err_clr  input  1  synchronous, one-cycle clear of timeout_err and relock_count.
- pll_rst  output  1  reset to the PLL, active-high.
- sys_rst  output  1  system reset to PLL-clocked logic, active-high. Consumers resynchronize it into their own domain.
- ready  output  1  high only while in RUN.
- timeout_err  output  1  sticky; set on any lock timeout.
- relock_count  output  8  count of lock losses while in RUN; saturates at 255.

Behaviour:
- Reset, while rst is high: state=PLL_RST, counter=0, sync chain=0, pll_rst=1, sys_rst=1, ready=0, timeout_err=0, relock_count=0.
- Outputs are registered and Moore-decoded from the next state: they change on the same edge as the state register.
- locked_s is pll_locked after SYNC_STAGES flops. All decisions use locked_s only.
- States:
  - PLL_RST:
    - pll_rst=1, sys_rst=1.
    - Counter counts 0..PLL_RST_CYCLES-1.
    - At terminal count: go to WAIT_LOCK with counter=0.
    - pll_rst is high for exactly PLL_RST_CYCLES cycles after rst deasserts.
  - WAIT_LOCK:
    - pll_rst=0, sys_rst=1.
    - locked_s=1: go to STABLE with counter=0.
    - Else, counter reaching LOCK_TIMEOUT_CYCLES-1: go to PLL_RST with counter=0 and set timeout_err.
  - STABLE:
    - pll_rst=0, sys_rst=1.
    - locked_s=0 in any cycle: return to WAIT_LOCK with counter=0. The timeout window restarts.
    - After LOCK_STABLE_CYCLES consecutive cycles with locked_s=1: go to RUN.
  - RUN:
    - pll_rst=0, sys_rst=0, ready=1; counter idle at 0.
    - locked_s=0: go to PLL_RST on that edge (sys_rst=1, ready=0, pll_rst=1).
    - relock_count += 1 on that edge, unless already 255.
- Latency: from the first refclk edge where pll_locked is seen high to sys_rst falling is SYNC_STAGES + LOCK_STABLE_CYCLES cycles, give or take one, provided lock holds.
- Lock glitch shorter than one refclk period may be missed; this is acceptable.
- err_clr:
  - Clears timeout_err and relock_count on the next edge.
  - If a timeout or lock loss occurs in the same cycle, the event wins: timeout_err=1, or relock_count=1 after the clear.
- rst mid-operation: immediate return to reset values regardless of state. Counter and sync chain are cleared.
- No path from WAIT_LOCK or STABLE directly to RUN, and no path from PLL_RST directly to STABLE.

Test Plan (PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, SYNC_STAGES=2):
- Normal bring-up:
  - Stimulus: release rst, raise pll_locked 10 cycles later.
  - Required: pll_rst high for exactly 4 cycles after release; sys_rst falls and ready rises 2+8 cycles (±1) after pll_locked rises; relock_count=0; timeout_err=0.
- Lock timeout:
  - Stimulus: pll_locked held at 0.
  - Required: pll_rst repeats 4-cycle pulses separated by 32 low cycles; timeout_err=1 after the first timeout; sys_rst stays 1.
- Unstable lock:
  - Stimulus: pll_locked high 5 cycles, low 3 cycles, then high.
  - Required: STABLE aborts; sys_rst falls only 8 consecutive locked_s cycles after the final rise; no pll_rst pulse, since the 32-cycle window is not exceeded.
- Lock loss in RUN:
  - Stimulus: drop pll_locked for 3 cycles, then restore.
  - Required: sys_rst=1 and pll_rst=1 exactly 2 cycles after the drop; pll_rst pulse lasts 4 cycles; relock_count=1; RUN re-entered after re-stabilisation.
- Saturation and clear:
  - Stimulus: 260 lock losses in RUN, then err_clr pulse; then err_clr coincident with a lock loss.
  - Required: relock_count reads 255; clears to 0 after err_clr; reads 1 after the coincident case.
- Reset mid-STABLE:
  - Stimulus: assert rst for 1 cycle during STABLE.
  - Required: all outputs return to reset values asynchronously; sequence restarts with a full 4-cycle pll_rst pulse.
